// File: rtl/gemm_pkg.sv
// Shared types and default sizing for the GEMM loop controller.
package gemm_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_e;

  localparam int GEMM_ITER_WIDTH = 14;
  localparam int GEMM_INP_AW     = 11;
  localparam int GEMM_WGT_AW     = 10;
  localparam int GEMM_ACC_AW     = 11;
  localparam int GEMM_PIPE_LAT   = 2;

endpackage

// File: rtl/gemm_addr_gen.sv
// Strided two-level address generator: addr = base + i*fo + j*fi, built from running sums.
module gemm_addr_gen #(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step,
  input  logic          wrap,
  input  logic          clear,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] fo,
  input  logic [AW-1:0] fi,
  output logic [AW-1:0] addr
);

  logic [AW-1:0] row_q, row_d;
  logic [AW-1:0] cur_q, cur_d;
  logic [AW-1:0] fo_q, fo_d;
  logic [AW-1:0] fi_q, fi_d;

  // row tracks base + i*fo; cur restarts from the next row whenever the inner index wraps
  always_comb begin
    row_d = row_q;
    cur_d = cur_q;
    fo_d  = fo_q;
    fi_d  = fi_q;
    if (clear) begin
      row_d = '0;
      cur_d = '0;
    end else if (load) begin
      row_d = base;
      cur_d = base;
      fo_d  = fo;
      fi_d  = fi;
    end else if (step) begin
      if (wrap) begin
        row_d = row_q + fo_q;
        cur_d = row_q + fo_q;
      end else begin
        cur_d = cur_q + fi_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      cur_q <= '0;
      fo_q  <= '0;
      fi_q  <= '0;
    end else begin
      row_q <= row_d;
      cur_q <= cur_d;
      fo_q  <= fo_d;
      fi_q  <= fi_d;
    end
  end

  assign addr = cur_q;

endmodule

// File: rtl/gemm_loop_ctrl.sv
// GEMM loop-nest sequencer: issues one inp/wgt/acc read triple per cycle and the
// matching accumulator write-back PIPE_LAT cycles later.
module gemm_loop_ctrl
  import gemm_pkg::*;
#(
  parameter int ITER_WIDTH = GEMM_ITER_WIDTH,
  parameter int INP_AW     = GEMM_INP_AW,
  parameter int WGT_AW     = GEMM_WGT_AW,
  parameter int ACC_AW     = GEMM_ACC_AW,
  parameter int PIPE_LAT   = GEMM_PIPE_LAT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ITER_WIDTH-1:0] cfg_iter_out,
  input  logic [ITER_WIDTH-1:0] cfg_iter_in,
  input  logic                  cfg_reset_acc,
  input  logic [INP_AW-1:0]     cfg_inp_base,
  input  logic [INP_AW-1:0]     cfg_inp_fo,
  input  logic [INP_AW-1:0]     cfg_inp_fi,
  input  logic [WGT_AW-1:0]     cfg_wgt_base,
  input  logic [WGT_AW-1:0]     cfg_wgt_fo,
  input  logic [WGT_AW-1:0]     cfg_wgt_fi,
  input  logic [ACC_AW-1:0]     cfg_acc_base,
  input  logic [ACC_AW-1:0]     cfg_acc_fo,
  input  logic [ACC_AW-1:0]     cfg_acc_fi,
  output logic                  busy,
  output logic                  done,
  output logic                  inp_rd_en,
  output logic [INP_AW-1:0]     inp_rd_addr,
  output logic                  wgt_rd_en,
  output logic [WGT_AW-1:0]     wgt_rd_addr,
  output logic                  acc_rd_en,
  output logic [ACC_AW-1:0]     acc_rd_addr,
  output logic                  acc_wr_en,
  output logic [ACC_AW-1:0]     acc_wr_addr,
  output logic                  mac_zero
);

  state_e                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  rd_en_q, rd_en_d;
  logic                  reset_acc_q, reset_acc_d;
  logic [ITER_WIDTH-1:0] iter_out_q, iter_out_d;
  logic [ITER_WIDTH-1:0] iter_in_q, iter_in_d;
  logic [ITER_WIDTH-1:0] i_q, i_d;
  logic [ITER_WIDTH-1:0] j_q, j_d;
  logic [2:0]            drain_q, drain_d;
  logic [PIPE_LAT-1:0]   wr_en_pipe_q, wr_en_pipe_d;
  logic [PIPE_LAT-1:0]   wr_zero_pipe_q, wr_zero_pipe_d;
  logic [ACC_AW-1:0]     wr_addr_pipe_q [PIPE_LAT];
  logic [ACC_AW-1:0]     wr_addr_pipe_d [PIPE_LAT];

  logic gen_load, gen_step, gen_wrap, gen_clear;
  logic j_last, i_last;

  assign j_last = (j_q == iter_in_q - ITER_WIDTH'(1));
  assign i_last = (i_q == iter_out_q - ITER_WIDTH'(1));

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rd_en_d     = rd_en_q;
    reset_acc_d = reset_acc_q;
    iter_out_d  = iter_out_q;
    iter_in_d   = iter_in_q;
    i_d         = i_q;
    j_d         = j_q;
    drain_d     = drain_q;
    gen_load    = 1'b0;
    gen_step    = 1'b0;
    gen_wrap    = 1'b0;
    gen_clear   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d      = 1'b1;
          reset_acc_d = cfg_reset_acc;
          iter_out_d  = cfg_iter_out;
          iter_in_d   = cfg_iter_in;
          i_d         = '0;
          j_d         = '0;
          if (cfg_iter_out == '0 || cfg_iter_in == '0) begin
            state_d = FIN;
          end else begin
            state_d  = ISSUE;
            rd_en_d  = 1'b1;
            gen_load = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (i_last && j_last) begin
          state_d   = DRAIN;
          rd_en_d   = 1'b0;
          gen_clear = 1'b1;
          drain_d   = '0;
          i_d       = '0;
          j_d       = '0;
        end else begin
          gen_step = 1'b1;
          gen_wrap = j_last;
          if (j_last) begin
            j_d = '0;
            i_d = i_q + ITER_WIDTH'(1);
          end else begin
            j_d = j_q + ITER_WIDTH'(1);
          end
        end
      end
      DRAIN: begin
        if (drain_q == 3'(PIPE_LAT - 1)) begin
          state_d = FIN;
        end else begin
          drain_d = drain_q + 3'd1;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // write-back shift register fed by the registered read issue
  always_comb begin
    wr_en_pipe_d[0]   = rd_en_q;
    wr_zero_pipe_d[0] = rd_en_q & reset_acc_q;
    wr_addr_pipe_d[0] = acc_rd_addr;
    for (int k = 1; k < PIPE_LAT; k++) begin
      wr_en_pipe_d[k]   = wr_en_pipe_q[k-1];
      wr_zero_pipe_d[k] = wr_zero_pipe_q[k-1];
      wr_addr_pipe_d[k] = wr_addr_pipe_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      rd_en_q        <= 1'b0;
      reset_acc_q    <= 1'b0;
      iter_out_q     <= '0;
      iter_in_q      <= '0;
      i_q            <= '0;
      j_q            <= '0;
      drain_q        <= '0;
      wr_en_pipe_q   <= '0;
      wr_zero_pipe_q <= '0;
      for (int k = 0; k < PIPE_LAT; k++) wr_addr_pipe_q[k] <= '0;
    end else begin
      state_q        <= state_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      rd_en_q        <= rd_en_d;
      reset_acc_q    <= reset_acc_d;
      iter_out_q     <= iter_out_d;
      iter_in_q      <= iter_in_d;
      i_q            <= i_d;
      j_q            <= j_d;
      drain_q        <= drain_d;
      wr_en_pipe_q   <= wr_en_pipe_d;
      wr_zero_pipe_q <= wr_zero_pipe_d;
      wr_addr_pipe_q <= wr_addr_pipe_d;
    end
  end

  gemm_addr_gen #(.AW(INP_AW)) u_inp_gen (
    .clk(clk), .rst_n(rst_n), .load(gen_load), .step(gen_step), .wrap(gen_wrap),
    .clear(gen_clear), .base(cfg_inp_base), .fo(cfg_inp_fo), .fi(cfg_inp_fi),
    .addr(inp_rd_addr)
  );

  gemm_addr_gen #(.AW(WGT_AW)) u_wgt_gen (
    .clk(clk), .rst_n(rst_n), .load(gen_load), .step(gen_step), .wrap(gen_wrap),
    .clear(gen_clear), .base(cfg_wgt_base), .fo(cfg_wgt_fo), .fi(cfg_wgt_fi),
    .addr(wgt_rd_addr)
  );

  gemm_addr_gen #(.AW(ACC_AW)) u_acc_gen (
    .clk(clk), .rst_n(rst_n), .load(gen_load), .step(gen_step), .wrap(gen_wrap),
    .clear(gen_clear), .base(cfg_acc_base), .fo(cfg_acc_fo), .fi(cfg_acc_fi),
    .addr(acc_rd_addr)
  );

  assign busy        = busy_q;
  assign done        = done_q;
  assign inp_rd_en   = rd_en_q;
  assign wgt_rd_en   = rd_en_q;
  assign acc_rd_en   = rd_en_q;
  assign acc_wr_en   = wr_en_pipe_q[PIPE_LAT-1];
  assign mac_zero    = wr_zero_pipe_q[PIPE_LAT-1];
  assign acc_wr_addr = wr_addr_pipe_q[PIPE_LAT-1];

endmodule
